lshift_sched: RTL and testbench

- Two-requester round-robin scheduler that shares one lshift_reg instance.
- Each requester submits an 8-bit value and a rotate count. The block loads the value through load_en/load_val, lets the register rotate left for the requested number of cycles, then captures op and returns it to the requester with a done pulse.
- It sits between client logic and lshift_reg, and it is the only driver of the register's load_val and load_en pins.

---
 rtl/lshift_sched.sv | 161 ++++++++++++++++
 tb/tb_lshift_sched.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/lshift_sched.sv
// Two-requester round-robin scheduler in front of a shared rotate-left register.
// Loads a requester's value, lets the register rotate cnt times, returns the result.
module lshift_sched #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             req0,
  input  logic [WIDTH-1:0] val0,
  input  logic [CNT_W-1:0] cnt0,
  input  logic             req1,
  input  logic [WIDTH-1:0] val1,
  input  logic [CNT_W-1:0] cnt1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic [WIDTH-1:0] sr_load_val,
  output logic             sr_load_en,
  input  logic [WIDTH-1:0] sr_op
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t           state_r, state_nxt_s;
  logic             sel_r, sel_nxt_s;
  logic             ptr_r, ptr_nxt_s;
  logic [WIDTH-1:0] val_q_r, val_q_nxt_s;
  logic [CNT_W-1:0] cnt_q_r, cnt_q_nxt_s;
  logic [CNT_W-1:0] j_r, j_nxt_s;
  logic [WIDTH-1:0] result_r, result_nxt_s;
  logic             gnt0_r, gnt0_nxt_s;
  logic             gnt1_r, gnt1_nxt_s;
  logic             done0_r, done0_nxt_s;
  logic             done1_r, done1_nxt_s;
  logic             busy_r, busy_nxt_s;
  logic             load_en_r, load_en_nxt_s;
  logic             win_s;

  // Tie-break: ptr remembers the last winner, so the other requester wins a tie.
  always_comb begin
    win_s = 1'b0;
    if (req0 && req1) begin
      win_s = ~ptr_r;
    end else begin
      win_s = req1;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt_s   = state_r;
    sel_nxt_s     = sel_r;
    ptr_nxt_s     = ptr_r;
    val_q_nxt_s   = val_q_r;
    cnt_q_nxt_s   = cnt_q_r;
    j_nxt_s       = j_r;
    result_nxt_s  = result_r;
    gnt0_nxt_s    = 1'b0;
    gnt1_nxt_s    = 1'b0;
    done0_nxt_s   = 1'b0;
    done1_nxt_s   = 1'b0;
    load_en_nxt_s = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (req0 || req1) begin
          state_nxt_s   = S_LOAD;
          sel_nxt_s     = win_s;
          ptr_nxt_s     = win_s;
          val_q_nxt_s   = win_s ? val1 : val0;
          cnt_q_nxt_s   = win_s ? cnt1 : cnt0;
          gnt0_nxt_s    = ~win_s;
          gnt1_nxt_s    = win_s;
          load_en_nxt_s = 1'b1;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_LOAD: begin
        j_nxt_s     = {CNT_W{1'b0}};
        state_nxt_s = S_SHIFT;
      end
      S_SHIFT: begin
        // sr_op already holds rotl(val_q, j) in this cycle.
        if (j_r == cnt_q_r) begin
          result_nxt_s = sr_op;
          state_nxt_s  = S_RESP;
          done0_nxt_s  = ~sel_r;
          done1_nxt_s  = sel_r;
        end else begin
          j_nxt_s = j_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      S_RESP: begin
        state_nxt_s = S_IDLE;
      end
      default: begin
        state_nxt_s = S_IDLE;
      end
    endcase
    busy_nxt_s = (state_nxt_s != S_IDLE);
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sel_r     <= 1'b0;
      ptr_r     <= 1'b1;
      val_q_r   <= {WIDTH{1'b0}};
      cnt_q_r   <= {CNT_W{1'b0}};
      j_r       <= {CNT_W{1'b0}};
      result_r  <= {WIDTH{1'b0}};
      gnt0_r    <= 1'b0;
      gnt1_r    <= 1'b0;
      done0_r   <= 1'b0;
      done1_r   <= 1'b0;
      busy_r    <= 1'b0;
      load_en_r <= 1'b0;
    end else begin
      sel_r     <= sel_nxt_s;
      ptr_r     <= ptr_nxt_s;
      val_q_r   <= val_q_nxt_s;
      cnt_q_r   <= cnt_q_nxt_s;
      j_r       <= j_nxt_s;
      result_r  <= result_nxt_s;
      gnt0_r    <= gnt0_nxt_s;
      gnt1_r    <= gnt1_nxt_s;
      done0_r   <= done0_nxt_s;
      done1_r   <= done1_nxt_s;
      busy_r    <= busy_nxt_s;
      load_en_r <= load_en_nxt_s;
    end
  end

  assign gnt0        = gnt0_r;
  assign gnt1        = gnt1_r;
  assign done0       = done0_r;
  assign done1       = done1_r;
  assign result      = result_r;
  assign busy        = busy_r;
  assign sr_load_val = val_q_r;
  assign sr_load_en  = load_en_r;

endmodule

// File: tb/tb_lshift_sched.sv
// Bench for lshift_sched: models the shared rotate register, predicts every
// output from an edge-indexed transaction model, and runs directed scenarios.
module tb_lshift_sched;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [7:0] val0 = 8'h00, val1 = 8'h00;
  logic [2:0] cnt0 = 3'd0, cnt1 = 3'd0;
  logic       gnt0, gnt1, done0, done1, busy, sr_load_en;
  logic [7:0] result, sr_load_val;
  logic [7:0] sr_op;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int n_gnt0 = 0;
  int n_done0 = 0;

  lshift_sched #(.WIDTH(8), .CNT_W(3)) dut (
    .clk(clk), .rstn(rstn),
    .req0(req0), .val0(val0), .cnt0(cnt0),
    .req1(req1), .val1(val1), .cnt1(cnt1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .result(result), .busy(busy),
    .sr_load_val(sr_load_val), .sr_load_en(sr_load_en), .sr_op(sr_op)
  );

  always #5 clk = ~clk;

  // The shared lshift_reg the scheduler drives.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) sr_op <= 8'h00;
    else if (sr_load_en) sr_op <= sr_load_val;
    else sr_op <= {sr_op[6:0], sr_op[7]};
  end

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int c);
    logic [15:0] w;
    w = {v, v} << c;
    return w[15:8];
  endfunction

  function automatic logic pick(input logic r0, input logic r1, input logic p);
    return (r0 && r1) ? !p : r1;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Transaction model: an accepted request on edge A makes gnt/load visible
  // after edge A, done after edge A+cnt+2, and the next accept possible at A+cnt+4.
  logic       m_active, m_sel, m_ptr;
  logic [7:0] m_val, m_result;
  int         m_cnt, m_acc, m_free;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_active <= 1'b0; m_sel <= 1'b0; m_ptr <= 1'b1;
      m_val <= 8'h00; m_result <= 8'h00;
      m_cnt <= 0; m_acc <= 0; m_free <= 0;
    end else begin
      if (m_active && (cyc + 1) == m_acc + m_cnt + 2) m_result <= rotl8(m_val, m_cnt);
      if ((cyc + 1) >= m_free && (req0 || req1)) begin
        m_active <= 1'b1;
        m_sel    <= pick(req0, req1, m_ptr);
        m_ptr    <= pick(req0, req1, m_ptr);
        m_val    <= pick(req0, req1, m_ptr) ? val1 : val0;
        m_cnt    <= pick(req0, req1, m_ptr) ? int'(cnt1) : int'(cnt0);
        m_acc    <= cyc + 1;
        m_free   <= cyc + 1 + (pick(req0, req1, m_ptr) ? int'(cnt1) : int'(cnt0)) + 4;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h want %0h", nm, cyc, got, exp);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(posedge clk) begin
    #1;
    chk("gnt0", gnt0, m_active && cyc == m_acc && !m_sel);
    chk("gnt1", gnt1, m_active && cyc == m_acc && m_sel);
    chk("load_en", sr_load_en, m_active && cyc == m_acc);
    if (m_active && cyc == m_acc) chk("load_val", sr_load_val, m_val);
    if (!rstn) chk("load_val_rst", sr_load_val, 8'h00);
    chk("done0", done0, m_active && cyc == m_acc + m_cnt + 2 && !m_sel);
    chk("done1", done1, m_active && cyc == m_acc + m_cnt + 2 && m_sel);
    chk("busy", busy, m_active && cyc >= m_acc && cyc <= m_acc + m_cnt + 2);
    chk("result", result, m_result);
  end

  // Pulse counters used by the reset and single-pulse scenarios.
  always @(posedge clk) begin
    #1;
    if (gnt0) n_gnt0 <= n_gnt0 + 1;
    if (done0) n_done0 <= n_done0 + 1;
  end

  // which: 0 gnt0, 1 gnt1, 2 done0, 3 done1, 4 any gnt, 5 any done
  task automatic wait_for(input int which, output int at);
    logic hit;
    at = -1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      case (which)
        0: hit = gnt0;
        1: hit = gnt1;
        2: hit = done0;
        3: hit = done1;
        4: hit = gnt0 | gnt1;
        default: hit = done0 | done1;
      endcase
      if (hit) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) chk("wait_timeout", 32'd0, 32'd1);
  endtask

  // gap = edges between gnt and done being seen; LOAD counts as cycle 1 after
  // acceptance, so done lands in cycle cnt+3, i.e. cnt+2 edges after gnt.
  task automatic run_op(input logic who, input logic [7:0] v, input logic [2:0] c,
                        input logic [7:0] exp_res, input int exp_gap);
    int g_at, d_at;
    @(posedge clk); #2;
    if (who) begin req1 = 1'b1; val1 = v; cnt1 = c; end
    else begin req0 = 1'b1; val0 = v; cnt0 = c; end
    wait_for(who ? 1 : 0, g_at);
    chk("op_load_en", sr_load_en, 1'b1);
    chk("op_load_val", sr_load_val, v);
    #1;
    req0 = 1'b0; req1 = 1'b0;
    wait_for(who ? 3 : 2, d_at);
    chk("op_result", result, exp_res);
    chk("op_gap", d_at - g_at, exp_gap);
    @(posedge clk); #1;
    chk("op_idle_busy", busy, 1'b0);
    chk("op_result_hold", result, exp_res);
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #2 rstn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout @cyc %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int at, d0_before, g0_before;
    logic [7:0] exp_res [4] = '{8'h02, 8'h40, 8'h02, 8'h40};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_gnt", {gnt0, gnt1, done0, done1}, 4'b0000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_result", result, 8'h00);
    chk("rst_load", {sr_load_en, sr_load_val}, 9'h000);
    #1 rstn = 1'b1;

    run_op(1'b0, 8'h01, 3'd3, 8'h08, 5);
    run_op(1'b1, 8'h5A, 3'd0, 8'h5A, 2);
    run_op(1'b0, 8'h81, 3'd1, 8'h03, 3);
    run_op(1'b0, 8'h80, 3'd7, 8'h40, 9);

    // Both held: first tie after reset goes to req0, then alternates.
    do_reset();
    @(posedge clk); #2;
    req0 = 1'b1; val0 = 8'h01; cnt0 = 3'd1;
    req1 = 1'b1; val1 = 8'h10; cnt1 = 3'd2;
    for (int i = 0; i < 4; i++) begin
      wait_for(4, at);
      chk("rr_order", gnt1, (i % 2 == 1) ? 1'b1 : 1'b0);
      if (i == 3) begin
        #1; req0 = 1'b0; req1 = 1'b0;
      end
      wait_for(5, at);
      chk("rr_result", result, exp_res[i]);
    end

    // Reset during SHIFT discards the operation.
    @(posedge clk); #2;
    req0 = 1'b1; val0 = 8'hFF; cnt0 = 3'd5;
    wait_for(0, at);
    #1 req0 = 1'b0;
    d0_before = n_done0;
    @(posedge clk); @(posedge clk);
    #3 rstn = 1'b0;
    #1;
    chk("midrst_outs", {gnt0, gnt1, done0, done1, busy, sr_load_en}, 6'b000000);
    chk("midrst_data", {result, sr_load_val}, 16'h0000);
    repeat (3) @(posedge clk);
    #2 rstn = 1'b1;
    repeat (8) @(posedge clk);
    #2;
    chk("midrst_no_done", n_done0 - d0_before, 0);
    run_op(1'b1, 8'h03, 3'd2, 8'h0C, 4);

    // One-cycle request; value changes right after grant.
    @(posedge clk); #2;
    g0_before = n_gnt0;
    req0 = 1'b1; val0 = 8'h11; cnt0 = 3'd2;
    @(posedge clk); #1;
    chk("pulse_gnt", gnt0, 1'b1);
    #1;
    req0 = 1'b0; val0 = 8'hEE; cnt0 = 3'd7;
    wait_for(2, at);
    chk("pulse_result", result, 8'h44);
    repeat (10) @(posedge clk);
    #2;
    chk("pulse_one_gnt", n_gnt0 - g0_before, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
